// File: rtl/bypass_scoreboard_pkg.sv
// Shared pipeline definitions for the bypass scoreboard: stage entry type,
// select encoding and the register-address equality comparator.
package bypass_scoreboard_pkg;

  localparam int DEFAULT_REG_AW = 5;
  // Stage entries carry rd at a fixed maximum width; narrower addresses are zero-extended.
  localparam int RD_MAX_W       = 8;
  localparam int SEL_REGFILE    = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                load;
  } stage_entry_t;

  function automatic logic reg_eq(input logic [RD_MAX_W-1:0] a,
                                  input logic [RD_MAX_W-1:0] b);
    return a == b;
  endfunction

  function automatic logic entry_live(input stage_entry_t e);
    return e.valid && e.we && (e.rd != '0);
  endfunction

endpackage

// File: rtl/bypass_scoreboard_match.sv
// bypass_match: combinational priority encoder returning the youngest live
// stage whose destination equals the source register (0 = register file).
module bypass_match
  import bypass_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  stage_entry_t [DEPTH:1] i_stages,
  input  logic [RD_MAX_W-1:0]    i_src,
  output logic [SEL_W-1:0]       o_sel
);

  always_comb begin
    // NOTE: default first so every path assigns o_sel and no latch is inferred.
    o_sel = SEL_W'(SEL_REGFILE);
    if (i_src != '0) begin
      // Scan oldest to youngest so the smallest matching k is the last write.
      for (int k = DEPTH; k >= 1; k--) begin
        if (entry_live(i_stages[k]) && reg_eq(i_stages[k].rd, i_src)) begin
          o_sel = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Bypass scoreboard: tracks destinations through DEPTH stages, produces forwarding
// selects and the load-use stall. Define BYPASS_SCOREBOARD_STATS_EN for stall/forward counters.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_we,
  input  logic              dec_load,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              stall
`ifdef BYPASS_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  stage_entry_t [DEPTH:1] r_stages;
  stage_entry_t           w_dec_entry;
  logic [RD_MAX_W-1:0]    w_src_a;
  logic [RD_MAX_W-1:0]    w_src_b;
  logic                   w_stall;

  assign w_src_a     = RD_MAX_W'(src_a);
  assign w_src_b     = RD_MAX_W'(src_b);
  assign w_dec_entry = '{valid: dec_valid, rd: RD_MAX_W'(dec_rd), we: dec_we, load: dec_load};

  // NOTE: the stage array is small control state, so it is reset in full; sequential state uses <= only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stages <= '0;
    end else if (flush) begin
      r_stages <= '0;
    end else if (advance) begin
      r_stages[1] <= w_stall ? '0 : w_dec_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        r_stages[k] <= r_stages[k-1];
      end
    end
  end

  bypass_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .i_stages (r_stages),
    .i_src    (w_src_a),
    .o_sel    (sel_a)
  );

  bypass_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .i_stages (r_stages),
    .i_src    (w_src_b),
    .o_sel    (sel_b)
  );

  generate
    if (DEPTH == 1) begin : g_no_stall
      // A single tracked stage is also the writeback stage, so a load there is never late.
      assign w_stall = 1'b0;
    end else begin : g_stall
      assign w_stall = dec_valid && entry_live(r_stages[1]) && r_stages[1].load &&
                       (((w_src_a != '0) && reg_eq(r_stages[1].rd, w_src_a)) ||
                        ((w_src_b != '0) && reg_eq(r_stages[1].rd, w_src_b)));
    end
  endgenerate

  assign stall = w_stall;

`ifdef BYPASS_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (advance && w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (advance && !w_stall && dec_valid && ((sel_a != '0) || (sel_b != '0))) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Randomised + directed scoreboard bench for bypass_scoreboard (DEPTH=3, REG_AW=5).
module tb_bypass_scoreboard;

  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int SEL_W  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              advance, flush, dec_valid, dec_we, dec_load;
  logic [REG_AW-1:0] dec_rd, src_a, src_b;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              stall;
`ifdef BYPASS_SCOREBOARD_STATS_EN
  logic [31:0]       stall_cnt, fwd_cnt;
`endif

  bypass_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_rd    (dec_rd),
    .dec_we    (dec_we),
    .dec_load  (dec_load),
    .src_a     (src_a),
    .src_b     (src_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .stall     (stall)
`ifdef BYPASS_SCOREBOARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    int          sel_a;
    int          sel_b;
    int          stall;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: list of in-flight instructions, index 1 = youngest.
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit ld;
  } instr_t;

  instr_t      pipe [1:DEPTH];
  logic [31:0] m_scnt, m_fcnt;
  int          cyc = 0;

  function automatic void model_clear();
    for (int k = 1; k <= DEPTH; k++) pipe[k] = '{0, 0, 0, 0};
    m_scnt = '0;
    m_fcnt = '0;
  endfunction

  function automatic int producer_of(input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (pipe[k].valid && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == src) return k;
    return 0;
  endfunction

  // One pipeline cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input bit adv, input bit fl, input bit dv, input int rd,
                       input bit we, input bit ld, input int sa, input int sb);
    exp_t e;
    bit   st;
    @(posedge clock);
    #1;
    advance = adv; flush = fl; dec_valid = dv;
    dec_rd = REG_AW'(rd); dec_we = we; dec_load = ld;
    src_a = REG_AW'(sa); src_b = REG_AW'(sb);
    // A load's value is not ready while it sits in the first stage after decode.
    st = dv && pipe[1].valid && pipe[1].we && pipe[1].rd != 0 && pipe[1].ld &&
         ((sa != 0 && pipe[1].rd == sa) || (sb != 0 && pipe[1].rd == sb));
    e.id = cyc; e.sel_a = producer_of(sa); e.sel_b = producer_of(sb);
    e.stall = int'(st); e.scnt = m_scnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);
    cyc++;
    if (adv && st) m_scnt = m_scnt + 1;
    if (adv && !st && dv && (e.sel_a != 0 || e.sel_b != 0)) m_fcnt = m_fcnt + 1;
    if (fl) begin
      for (int k = 1; k <= DEPTH; k++) pipe[k].valid = 0;
    end else if (adv) begin
      for (int k = DEPTH; k >= 2; k--) pipe[k] = pipe[k-1];
      if (st) pipe[1] = '{0, 0, 0, 0};
      else    pipe[1] = '{dv, rd, we, ld};
    end
  endtask

  task automatic idle_inputs();
    advance = 0; flush = 0; dec_valid = 0; dec_rd = '0; dec_we = 0;
    dec_load = 0; src_a = '0; src_b = '0;
  endtask

  // Monitor: compares every predicted cycle at the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("sel_a@%0d", e.id), 64'(sel_a), 64'(e.sel_a));
      check($sformatf("sel_b@%0d", e.id), 64'(sel_b), 64'(e.sel_b));
      check($sformatf("stall@%0d", e.id), 64'(stall), 64'(e.stall));
`ifdef BYPASS_SCOREBOARD_STATS_EN
      check($sformatf("stall_cnt@%0d", e.id), 64'(stall_cnt), 64'(e.scnt));
      check($sformatf("fwd_cnt@%0d", e.id), 64'(fwd_cnt), 64'(e.fcnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    idle_inputs();
    reset = 1'b0;
    // Reset state, with inputs that would otherwise hit.
    src_a = 5'd5; src_b = 5'd7; dec_valid = 1;
    repeat (2) @(posedge clock);
    #2;
    check("reset_sel_a", 64'(sel_a), 64'd0);
    check("reset_sel_b", 64'(sel_b), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    idle_inputs();
    reset = 1'b1;

    // Forwarding from stage 1 then stage 2.
    cycle(1, 0, 1, 5, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 5, 0);
    cycle(1, 0, 1, 0, 0, 0, 5, 0);

    // Priority: stage 1 and stage 3 both write r7.
    cycle(1, 0, 1, 7, 1, 0, 0, 0);
    cycle(1, 0, 1, 2, 0, 0, 0, 0);
    cycle(1, 0, 1, 7, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 7);

    // Load-use: one stall, then forward from stage 2.
    cycle(1, 0, 1, 9, 1, 1, 0, 0);
    cycle(1, 0, 1, 3, 1, 0, 9, 0);
    cycle(1, 0, 1, 3, 1, 0, 9, 0);
    cycle(0, 0, 0, 0, 0, 0, 3, 0);

    // r0 is never forwarded; we=0 entries are never forwarded.
    cycle(1, 0, 1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 4, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 4);

    // Load in the other operand, with advance held low (stall repeats).
    cycle(1, 0, 1, 11, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 1, 0, 0, 11);
    cycle(1, 0, 1, 1, 1, 0, 0, 11);
    cycle(1, 0, 1, 1, 1, 0, 0, 11);

    // Flush with advance while entries are live.
    cycle(1, 0, 1, 6, 1, 1, 0, 0);
    cycle(1, 1, 1, 8, 1, 0, 6, 6);
    cycle(1, 0, 1, 0, 0, 0, 6, 8);

    // Reset in the middle of a stall.
    cycle(1, 0, 1, 9, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 9, 0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_stall", 64'(stall), 64'd0);
    check("midreset_sel_a", 64'(sel_a), 64'd0);
    model_clear();
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b1;
    cycle(0, 0, 1, 0, 0, 0, 9, 9);

    // Randomised traffic over a small register set to force frequent hits.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
            $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    @(posedge clock);
    #1;
    idle_inputs();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, giving the register address width.
REQ-002 SHALL have parameter DEPTH, default 3, giving the number of tracked stages after decode (stage 1 = X, stage DEPTH = W); legal range 1..7.
REQ-003 SHALL have parameter SEL_W, default 2, giving the select width; it SHALL be ceil(log2(DEPTH+1)).
REQ-004 One clock and asynchronous active-low reset: `clock` input 1 = rising-edge clock; `reset` input 1 = asynchronous active-low reset.
REQ-005 `advance` input 1 = pipeline moves one stage this cycle.
REQ-006 `flush` input 1 = kill all tracked entries.
REQ-007 `dec_valid` input 1 = the decode slot holds a real instruction.
REQ-008 `dec_rd` input REG_AW = destination register of the decode instruction.
REQ-009 `dec_we` input 1 = the decode instruction writes `dec_rd`.
REQ-010 `dec_load` input 1 = the decode instruction is a load; its result is first valid at stage 2.
REQ-011 `src_a` and `src_b` inputs, REG_AW each, = decode source registers.
REQ-012 `sel_a` and `sel_b` outputs, SEL_W each, = bypass select: 0 = register file, k = stage k result.
REQ-013 `stall` output 1 = hold decode and insert a bubble.

Function
REQ-014 Each stage k SHALL hold {valid, rd, we, load}; the entry is "live" when valid && we && rd != 0.
REQ-015 On `advance` && !`stall`: stage 1 SHALL load the decode fields, gated by `dec_valid`, and stage k SHALL load stage k-1 for k = 2..DEPTH.
REQ-016 On `advance` && `stall`: stage 1 SHALL load a bubble (valid = 0), and stages 2..DEPTH SHALL shift.
REQ-017 With `advance` = 0, all stages SHALL hold.
REQ-018 `sel_x` SHALL be the smallest k for which stage k is live and its rd equals src_x; it SHALL be 0 if there is no match.
REQ-019 `sel_x` SHALL be 0 whenever src_x = 0.
REQ-020 The select path SHALL be combinational, with zero latency from src/stage state.
REQ-021 `stall` SHALL be 1 when `dec_valid` is 1 and stage 1 is live with load = 1 and its rd equals a nonzero src_a or src_b.
REQ-022 When `stall` is 1, the `sel_a` and `sel_b` values SHALL be don't-care for the consumer but SHALL still follow REQ-018.
REQ-023 A load-use hazard SHALL cost exactly one stall cycle per `advance`. After the bubble, the load sits in stage 2 and its result is forwarded with sel = 2.
REQ-024 `flush` SHALL clear every valid bit on the next clock edge and SHALL take priority over `advance`.
REQ-025 `stall` SHALL be 0 in the cycle after a `flush`.
REQ-026 When DEPTH = 1, stall generation SHALL be disabled and `stall` SHALL be tied to 0.

Reset
REQ-027 Asserting `reset` low SHALL asynchronously clear all valid, we and load bits to 0 and all rd fields to 0.
REQ-028 While in reset, `sel_a`/`sel_b` SHALL be 0 and `stall` SHALL be 0.
REQ-029 Deassertion of `reset` SHALL be synchronised externally; the block SHALL sample normally from the first rising edge after deassertion.

Configuration
REQ-030 The macro BYPASS_SCOREBOARD_STATS_EN, when defined, SHALL add two outputs, `stall_cnt` and `fwd_cnt`, each 32 bits.
REQ-031 With BYPASS_SCOREBOARD_STATS_EN defined, `stall_cnt` SHALL increment on each cycle where `advance` && `stall`.
REQ-032 With BYPASS_SCOREBOARD_STATS_EN defined, `fwd_cnt` SHALL increment on each cycle where `advance` && !`stall` && `dec_valid` && (`sel_a` != 0 || `sel_b` != 0).
REQ-033 Both counters SHALL reset to 0, SHALL wrap modulo 2^32, and SHALL not be cleared by `flush`.
REQ-034 With BYPASS_SCOREBOARD_STATS_EN undefined, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 The shared pipeline package SHALL hold the stage-entry typedef {valid, rd, we, load}, the SEL_REGFILE = 0 constant and the default REG_AW.
REQ-036 The block SHALL use one sub-module, `bypass_match`, instantiated per source operand. It is a combinational priority encoder that takes the stage array and a src and returns sel.
REQ-037 Register-address equality SHALL reuse the existing equality comparator.

Verification
REQ-038 Forwarding: DEPTH = 3; issue `add r5` with advance every cycle, then `dec src_a = 5` one cycle later -> `sel_a` = 1, and two cycles later -> `sel_a` = 2.
REQ-039 Priority: stage 1 and stage 3 both write r7; `src_b` = 7 -> `sel_b` = 1 (youngest wins).
REQ-040 Load-use: stage 1 holds `load r9`; `src_a` = 9 -> `stall` = 1 for one advance. The next cycle gives `stall` = 0 and `sel_a` = 2, and stage 1 is a bubble.
REQ-041 r0 and we: `src_a` = 0 with a live stage-1 rd = 0 -> `sel_a` = 0. A matching entry with we = 0 -> `sel` = 0.
REQ-042 Flush/reset: with live entries, `flush` plus `advance` -> all `sel` = 0 and `stall` = 0 next cycle. Asserting `reset` mid-stall -> `stall` drops immediately and the stages clear.
REQ-043 Stats (BYPASS_SCOREBOARD_STATS_EN defined): 3 load-use stalls and 5 forwarded issues -> `stall_cnt` = 3 and `fwd_cnt` = 5. Preload `stall_cnt` = 0xFFFFFFFF, then one stall -> 0.
